// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product load/compute sequencer.
package dot_pkg;

  localparam int unsigned DefDataInBits   = 4;
  localparam int unsigned DefPipeStages   = 4;
  localparam int unsigned DefDataWidthIn  = 8;
  localparam int unsigned DefDataWidthOut = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StPad,
    StCompute,
    StDone
  } dot_state_e;

  // Operand pair on the stream and into the SRAMs: b in the high half, a in the low half.
  typedef struct packed {
    logic [DefDataWidthIn-1:0] b;
    logic [DefDataWidthIn-1:0] a;
  } dot_pair_t;

  // Datapath step count at which the accumulated result is final.
  function automatic int unsigned total_steps(input int unsigned data_in_bits,
                                              input int unsigned pipe_stages);
    return (32'd1 << data_in_bits) + pipe_stages - 32'd1;
  endfunction

endpackage

// File: rtl/dot_load_sequencer_if.sv
// Operand stream in, result stream out; slave is the sequencer side.
interface dot_load_sequencer_if #(
  parameter int unsigned Data_Width_In  = 8,
  parameter int unsigned Data_Width_Out = 16
) ();

  logic                         s_valid;
  logic                         s_ready;
  logic [2*Data_Width_In-1:0]   s_data;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic [Data_Width_Out-1:0]    m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/dot_beat_counter.sv
// Element counter for one job: synchronous clear, increment, terminal-count flag.
module dot_beat_counter #(
  parameter int unsigned CntBits  = 5,
  parameter int unsigned Terminal = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [CntBits-1:0] cnt_o,
  output logic               tc_o
);

  logic [CntBits-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CntBits'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CntBits'(Terminal));

endmodule

// File: rtl/dot_load_sequencer.sv
// Feeds operand pairs into the dot-product datapath SRAMs, runs compute, returns the result.
module dot_load_sequencer
  import dot_pkg::*;
#(
  parameter int unsigned Nums_Data_in_bits    = DefDataInBits,
  parameter int unsigned Nums_Pipeline_Stages = DefPipeStages,
  parameter int unsigned Data_Width_In        = DefDataWidthIn,
  parameter int unsigned Data_Width_Out       = DefDataWidthOut
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         acc_en,
  dot_load_sequencer_if.slave          bus,
  output logic                         dp_Mem_Index_reset,
  output logic                         dp_Comp_reset,
  output logic                         dp_PE_reset,
  output logic                         dp_load_from_file,
  output logic [2*Data_Width_In-1:0]   dp_input_data,
  output logic                         dp_Computing,
  output logic                         dp_load_old_output,
  input  logic [Nums_Data_in_bits:0]   dp_state,
  input  logic [Data_Width_Out-1:0]    dp_result,
  output logic                         busy,
  output logic                         len_err
);

  localparam int unsigned Nums_Data               = 1 << Nums_Data_in_bits;
  localparam int unsigned Total_Computation_Steps =
      total_steps(Nums_Data_in_bits, Nums_Pipeline_Stages);
  localparam int unsigned CntBits                 = Nums_Data_in_bits + 1;

  localparam logic [CntBits-1:0] StepsDone = CntBits'(Total_Computation_Steps);

  dot_state_e                state_q;
  dot_state_e                state_eff;
  logic                      acc_q;
  logic                      len_err_q;
  logic                      comp_first_q;
  logic [Data_Width_Out-1:0] m_data_q;

  logic                      beat_fire;
  logic                      cnt_clr;
  logic                      cnt_tc;
  logic [CntBits-1:0]        cnt;
  logic                      comp_pulse;

  // Reset is synchronous to the state, but every output must already look idle while held.
  assign state_eff = reset_n ? state_q : StIdle;

  assign beat_fire  = (state_eff == StLoad) && bus.s_valid;
  assign cnt_clr    = (state_eff == StClear);
  assign comp_pulse = (state_eff == StCompute) && comp_first_q;

  dot_beat_counter #(
    .CntBits  (CntBits),
    .Terminal (Nums_Data - 1)
  ) u_beat_counter (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (cnt_clr),
    .inc_i  (dp_load_from_file),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      acc_q        <= 1'b0;
      len_err_q    <= 1'b0;
      comp_first_q <= 1'b0;
      m_data_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q     <= acc_en;
            len_err_q <= 1'b0;
            state_q   <= StClear;
          end
        end
        StClear: state_q <= StLoad;
        StLoad: begin
          if (beat_fire) begin
            if (cnt_tc) begin
              state_q      <= StCompute;
              comp_first_q <= 1'b1;
              if (!bus.s_last) len_err_q <= 1'b1;
            end else if (bus.s_last) begin
              state_q   <= StPad;
              len_err_q <= 1'b1;
            end
          end
        end
        StPad: begin
          if (cnt_tc) begin
            state_q      <= StCompute;
            comp_first_q <= 1'b1;
          end
        end
        StCompute: begin
          comp_first_q <= 1'b0;
          if (!comp_first_q && (dp_state == StepsDone)) begin
            m_data_q <= dp_result;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (bus.m_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.s_ready        = (state_eff == StLoad);
    bus.m_valid        = (state_eff == StDone);
    bus.m_data         = reset_n ? m_data_q : '0;
    busy               = (state_eff != StIdle);
    len_err            = reset_n && len_err_q;
    dp_Mem_Index_reset = !reset_n || cnt_clr;
    dp_Comp_reset      = !reset_n || cnt_clr || comp_pulse;
    dp_PE_reset        = !reset_n || cnt_clr || comp_pulse;
    dp_load_from_file  = beat_fire || (state_eff == StPad);
    dp_input_data      = beat_fire ? bus.s_data : '0;
    // Drops in the same cycle the datapath reports the final step, so it never over-counts.
    dp_Computing       = (state_eff == StCompute) && !comp_first_q && (dp_state != StepsDone);
    dp_load_old_output = acc_q && ((state_eff == StCompute) || (state_eff == StDone));
  end

endmodule

// File: tb/tb_dot_load_sequencer.sv
// Randomized scoreboard bench for dot_load_sequencer with a behavioural datapath model.
module tb_dot_load_sequencer;
  import dot_pkg::*;

  localparam int unsigned N  = 16;
  localparam int unsigned T  = 19;
  localparam int unsigned SW = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        acc_en = 1'b0;
  logic        dp_Mem_Index_reset, dp_Comp_reset, dp_PE_reset, dp_load_from_file;
  logic [15:0] dp_input_data;
  logic        dp_Computing, dp_load_old_output, busy, len_err;
  logic [SW-1:0] dp_state = '0;
  logic [15:0] dp_result = '0;

  always #5 clk = ~clk;

  dot_load_sequencer_if #(.Data_Width_In(8), .Data_Width_Out(16)) bus ();

  dot_load_sequencer #(
    .Nums_Data_in_bits    (4),
    .Nums_Pipeline_Stages (4),
    .Data_Width_In        (8),
    .Data_Width_Out       (16)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .acc_en             (acc_en),
    .bus                (bus.slave),
    .dp_Mem_Index_reset (dp_Mem_Index_reset),
    .dp_Comp_reset      (dp_Comp_reset),
    .dp_PE_reset        (dp_PE_reset),
    .dp_load_from_file  (dp_load_from_file),
    .dp_input_data      (dp_input_data),
    .dp_Computing       (dp_Computing),
    .dp_load_old_output (dp_load_old_output),
    .dp_state           (dp_state),
    .dp_result          (dp_result),
    .busy               (busy),
    .len_err            (len_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath model: SRAM fill via load port, step counter, result latched at the final step.
  logic [7:0]  mem_a [N];
  logic [7:0]  mem_b [N];
  logic [SW-1:0] idx = '0;

  function automatic logic [15:0] mem_dot();
    logic [15:0] s = '0;
    for (int i = 0; i < int'(N); i++) s = s + 16'(mem_a[i] * mem_b[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (dp_Mem_Index_reset) idx <= '0;
    else if (dp_load_from_file && idx < SW'(N)) begin
      mem_a[idx[3:0]] <= dp_input_data[7:0];
      mem_b[idx[3:0]] <= dp_input_data[15:8];
      idx <= idx + 1'b1;
    end
    if (dp_Comp_reset) dp_state <= '0;
    else if (dp_Computing) begin
      dp_state <= dp_state + 1'b1;
      if (int'(dp_state) + 1 == int'(T))
        dp_result <= (dp_load_old_output ? dp_result : 16'd0) + mem_dot();
    end
  end

  // Scoreboard
  typedef struct {
    logic [15:0] data;
    logic        lerr;
    logic        acc;
  } exp_t;
  exp_t        sb_q[$];
  logic [15:0] model_old = '0;

  // Result-side ready driver
  int hold_target = 0;
  bit ready_rand = 1'b0;
  int valid_cycles = 0;
  initial bus.m_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (bus.m_valid) valid_cycles++;
    else valid_cycles = 0;
    if (bus.m_valid && valid_cycles <= hold_target) bus.m_ready = 1'b0;
    else bus.m_ready = ready_rand ? 1'($urandom % 2) : 1'b1;
  end

  // Monitor
  int          wr_cnt = 0;
  int          max_st = 0;
  bit          acc_bad = 0;
  bit          stable_bad = 0;
  bit          prev_valid = 0;
  bit          drop_pend = 0;
  logic [15:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (dp_Mem_Index_reset) begin
      wr_cnt = 0; max_st = 0; acc_bad = 0;
    end else if (dp_load_from_file) wr_cnt++;
    if (int'(dp_state) > max_st) max_st = int'(dp_state);
    if (sb_q.size() > 0 && (dp_Computing || bus.m_valid) && dp_load_old_output !== sb_q[0].acc)
      acc_bad = 1;
    if (dp_load_from_file && dp_load_old_output) acc_bad = 1;
    if (drop_pend) begin
      check("m_valid_drop", 32'(bus.m_valid), 32'd0);
      drop_pend = 0;
    end
    if (bus.m_valid) begin
      if (prev_valid && bus.m_data !== held) stable_bad = 1;
      held = bus.m_data;
    end
    prev_valid = bus.m_valid;
    if (bus.m_valid && bus.m_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("m_data", 32'(bus.m_data), 32'(e.data));
        check("len_err", 32'(len_err), 32'(e.lerr));
        check("write_count", 32'(wr_cnt), 32'(N));
        check("final_step", 32'(max_st), 32'(T));
        check("old_output_ctl", 32'(acc_bad), 32'd0);
        check("m_data_stable", 32'(stable_bad), 32'd0);
      end
      drop_pend = 1;
      stable_bad = 0;
      prev_valid = 0;
    end
  end

  // Stimulus
  task automatic drive_beats(input int nb, input int last_idx, input int a_v[N],
                             input int b_v[N], input int vmode);
    int i = 0;
    int tmo = 0;
    bit acc;
    while (i < nb) begin
      bus.s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(tmo % 2 == 0) : 1'($urandom % 3 != 0);
      bus.s_data  = {8'(b_v[i]), 8'(a_v[i])};
      bus.s_last  = (i == last_idx);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      tmo++;
      if (tmo > 1000) begin
        check("beat_timeout", 32'(i), 32'(nb));
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 16'($urandom) | 16'h0101;
  endtask

  // dmode: 0 random, 1 a=i+1/b=2, 2 all ones. len>16 means no s_last within the vector.
  task automatic run_job(input int len, input bit acc, input int dmode, input int vmode,
                         input int hold, input bit rrand, input bit start_mid);
    int a_v[N];
    int b_v[N];
    int nb;
    int tmo;
    exp_t e;
    logic [15:0] sum = '0;
    nb = (len < int'(N)) ? len : int'(N);
    for (int i = 0; i < int'(N); i++) begin
      a_v[i] = (dmode == 1) ? i + 1 : (dmode == 2) ? 1 : int'($urandom_range(0, 255));
      b_v[i] = (dmode == 1) ? 2 : (dmode == 2) ? 1 : int'($urandom_range(0, 255));
    end
    for (int i = 0; i < nb; i++) sum = sum + 16'(a_v[i] * b_v[i]);
    e.data = (acc ? model_old : 16'd0) + sum;
    e.lerr = (len != int'(N));
    e.acc  = acc;
    model_old = e.data;
    sb_q.push_back(e);
    hold_target = hold;
    ready_rand  = rrand;
    start = 1'b1; acc_en = acc;
    @(posedge clk); #1;
    start = 1'b0; acc_en = 1'b0;
    @(negedge clk);
    check("clear_pulse", 32'({dp_Mem_Index_reset, dp_Comp_reset, dp_PE_reset}), 32'd7);
    @(posedge clk); #1;
    drive_beats(nb, (len <= int'(N)) ? len - 1 : -1, a_v, b_v, vmode);
    @(negedge clk);
    check("s_ready_after_last", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    if (start_mid) begin
      start = 1'b1; acc_en = ~acc;
      @(posedge clk); #1;
      start = 1'b0; acc_en = 1'b0;
    end
    tmo = 0;
    while (busy && tmo < 500) begin
      @(posedge clk); #1;
      tmo++;
    end
    check("job_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int none_a[N];
    int none_b[N];
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", 32'({busy, bus.s_ready, bus.m_valid, len_err}), 32'd0);
    check("rst_dp_resets", 32'({dp_Mem_Index_reset, dp_Comp_reset, dp_PE_reset}), 32'd7);
    check("rst_dp_ctl", 32'({dp_load_from_file, dp_Computing, dp_load_old_output}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_resets_low", 32'({dp_Mem_Index_reset, dp_Comp_reset, dp_PE_reset}), 32'd0);
    @(posedge clk); #1;

    run_job(16, 1'b0, 1, 0, 0, 1'b0, 1'b0);  // full vector, expect 272
    run_job(10, 1'b0, 2, 0, 0, 1'b0, 1'b0);  // short vector, expect 10
    run_job(16, 1'b0, 0, 1, 5, 1'b0, 1'b0);  // bubbles and stalled result
    run_job(16, 1'b1, 0, 2, 2, 1'b1, 1'b1);  // accumulate, stray start mid-job

    // Reset in the middle of LOAD
    for (int i = 0; i < int'(N); i++) begin none_a[i] = i; none_b[i] = 3; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    drive_beats(7, -1, none_a, none_b, 0);
    bus.s_valid = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_resets", 32'({dp_Mem_Index_reset, dp_Comp_reset, dp_PE_reset}), 32'd7);
    check("midrst_no_write", 32'(dp_load_from_file), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; bus.s_valid = 1'b0;
    @(negedge clk);
    check("midrst_idle", 32'({busy, bus.s_ready, bus.m_valid}), 32'd0);
    @(posedge clk); #1;

    run_job(17, 1'b0, 0, 0, 0, 1'b0, 1'b0);  // missing s_last
    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(1, 20)), 1'($urandom % 2), 0, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 4)), 1'($urandom % 2), 1'($urandom % 2));

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_load_sequencer.md
Name: dot_load_sequencer

Overview:
- Upstream control-and-feed stage for the dot-product datapath.
- Accepts a stream of operand pairs (a, b) over a valid/ready handshake and writes them into the input SRAMs through the datapath's load-from-file port.
- Then runs the compute phase and returns the final dot-product result on a valid/ready output.
- Drives every control input of the datapath, so the datapath needs no other sequencing logic.

Parameters:
- Nums_Data_in_bits, 4, log2 of vector length.
- Nums_Data, 1 << Nums_Data_in_bits, elements per job.
- Nums_Pipeline_Stages, 4, datapath multiply/accumulate pipeline depth.
- Total_Computation_Steps, Nums_Data + Nums_Pipeline_Stages - 1, state count at which the result is final (19 at defaults).
- Data_Width_In, 8, operand width.
- Data_Width_Out, 16, result width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a job; sampled in IDLE only
- acc_en  in  1  accumulate onto the old output; latched at start
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when s_valid && s_ready
- s_data  in  2*Data_Width_In  {b, a}; a in the low half
- s_last  in  1  final beat of the vector
- dp_Mem_Index_reset  out  1  datapath address-index reset
- dp_Comp_reset  out  1  datapath step-counter reset
- dp_PE_reset  out  1  datapath PE reset
- dp_load_from_file  out  1  datapath SRAM write strobe, one per element
- dp_input_data  out  2*Data_Width_In  element pair written to the input SRAMs
- dp_Computing  out  1  datapath compute enable
- dp_load_old_output  out  1  latched acc_en
- dp_state  in  Nums_Data_in_bits+1  datapath step counter
- dp_result  in  Data_Width_Out  datapath result
- m_valid  out  1  result valid
- m_ready  in  1  result accepted when m_valid && m_ready
- m_data  out  Data_Width_Out  captured result
- busy  out  1  high in any state other than IDLE
- len_err  out  1  sticky flag: length mismatch in the last job

Behaviour:
- Reset (reset_n=0 at a clk edge), including mid-job:
  - state goes to IDLE; beat counter cleared.
  - All outputs 0, except dp_Mem_Index_reset, dp_Comp_reset and dp_PE_reset, which are driven 1 while reset_n=0.
  - Any job in flight is abandoned; no m_valid is produced for it.
- State machine: IDLE -> CLEAR -> LOAD -> (PAD) -> COMPUTE -> DONE -> IDLE.
- IDLE
  - s_ready=0.
  - On start=1: latch acc_en, clear len_err, go to CLEAR.
- CLEAR (exactly 1 cycle)
  - dp_Mem_Index_reset, dp_Comp_reset and dp_PE_reset all 1; go to LOAD.
- LOAD
  - s_ready=1.
  - Each accepted beat: dp_load_from_file=1 and dp_input_data=s_data in the same cycle (combinational pass-through, zero latency); beat counter +1.
  - dp_load_from_file=0 on cycles with no accepted beat; bubbles are allowed.
  - Accepted beat with counter == Nums_Data-1: go to COMPUTE. If s_last=0 on that beat, set len_err and deassert s_ready from the next cycle. Excess beats stay upstream for the next job.
  - Accepted beat with s_last=1 and counter < Nums_Data-1: set len_err and go to PAD.
- PAD
  - s_ready=0.
  - dp_load_from_file=1 with dp_input_data=0 each cycle until the counter reaches Nums_Data, then go to COMPUTE.
  - Zero-padding leaves the dot product unchanged.
- COMPUTE
  - The cycle after entry: dp_Comp_reset pulses 1 for 1 cycle and dp_PE_reset pulses 1 for 1 cycle.
  - Then dp_Computing=1 until dp_state == Total_Computation_Steps.
  - In that cycle: register dp_result into m_data, drop dp_Computing, go to DONE.
- DONE
  - m_valid=1 and m_data held stable until m_ready.
  - On handshake: m_valid drops next cycle, go to IDLE.
  - If start is already high in that cycle, it is ignored; start is re-sampled in IDLE.
- Other rules:
  - dp_load_old_output equals the latched acc_en during COMPUTE and DONE; 0 otherwise.
  - Beat counter is Nums_Data_in_bits+1 bits wide and never wraps within a job.
  - No arithmetic is performed here; widths pass through unchanged.
  - start asserted outside IDLE is ignored.
  - A stalled m_ready holds DONE indefinitely; there is no timeout.

Decomposition:
- Shared package dot_pkg:
  - state enum {IDLE, CLEAR, LOAD, PAD, COMPUTE, DONE}.
  - Total_Computation_Steps derivation.
  - Operand-pair packing order.
- One natural sub-module: dot_beat_counter, holding the element counter with clear, increment and terminal-count outputs.
- The FSM and output registers stay in the top module.

Test Plan (defaults, Nums_Data=16):
- Full vector: a=i+1, b=2, i=0..15, s_last on beat 15, m_ready=1 → exactly 16 dp_load_from_file pulses; dp_Computing high until dp_state==19; m_data=272; len_err=0.
- Short vector: 10 beats of a=1, b=1, s_last on beat 9 → 6 pad writes with dp_input_data=0; m_data=10; len_err=1.
- Backpressure: s_valid toggling 1/0 and m_ready held 0 for 5 cycles → write count still 16, m_data stable while m_valid=1, single handshake.
- Accumulate: acc_en=1 at start → dp_load_old_output=1 throughout COMPUTE and DONE; acc_en dropped mid-job has no effect.
- Reset mid-LOAD after 7 beats → next cycle busy=0, s_ready=0, m_valid=0; a new job restarts with CLEAR pulses.
- Missing s_last: 16 beats with s_last=0 → len_err=1, s_ready=0 after beat 15, no 17th write.
